// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read sync FIFO into a valid/ready
// stream with packet framing. A 2-entry skid buffer absorbs the FIFO's
// one-cycle read latency so the stream runs at one beat per cycle.
//
// Ports:
//   clk       clock, all logic on posedge
//   rstn      synchronous reset, active-high (1 = reset)
//   i_en      drain enable; dropping it requests a graceful stop
//   i_empty   FIFO empty flag
//   o_rden    FIFO read enable (combinational)
//   i_rddata  FIFO read data, valid the cycle after o_rden
//   o_valid   stream valid
//   i_ready   stream ready
//   o_data    stream data (skid buffer head)
//   o_last    final beat of a packet, qualified by o_valid
//   o_busy    high while running or draining
// Optional (macro FIFO_RD_STREAM_PKTCNT_EN):
//   o_pkt_cnt   completed packet count, wraps
//   o_underrun  sticky: consumer ready, nothing to give, FIFO empty
module fifo_rd_stream #(
  parameter int WIDTH   = 128,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_empty,
  output logic             o_rden,
  input  logic [WIDTH-1:0] i_rddata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
`ifdef FIFO_RD_STREAM_PKTCNT_EN
  output logic [CNT_W-1:0] o_pkt_cnt,
  output logic             o_underrun,
`endif
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;
  logic             inflight_q;
  logic [CNT_W-1:0] beat_q;

  logic             pop;
  logic [2:0]       occ_nxt;
  logic [1:0]       occ_d;
  logic             is_last;

  // The word returning from the FIFO is visible the same cycle it is
  // captured, so an empty buffer adds no latency.
  assign o_valid = (occ_q != 2'd0) | inflight_q;
  assign o_data  = (occ_q != 2'd0) ? mem_q[rd_ptr_q]
                 : (inflight_q ? i_rddata : '0);
  assign pop     = o_valid & i_ready;

  // Occupancy after this edge, before any new read returns.
  assign occ_nxt = {1'b0, occ_q}
                 + {2'b0, inflight_q}
                 - {2'b0, pop};
  assign occ_d   = occ_nxt[1:0];

  // Only issue if the returning word is guaranteed a free slot.
  assign o_rden  = ~rstn
                 & (state_q == RUN)
                 & i_en
                 & ~i_empty
                 & (occ_nxt < 3'd2);

  assign is_last = (beat_q == CNT_W'(PKT_LEN - 1));
  assign o_last  = o_valid & is_last;
  assign o_busy  = (state_q != IDLE);

`ifdef FIFO_RD_STREAM_PKTCNT_EN
  logic [CNT_W-1:0] pkt_q;
  logic             und_q;
  assign o_pkt_cnt  = pkt_q;
  assign o_underrun = und_q;
`endif

  // Storage only; with occ==0 the tail and head coincide, so a
  // capture-and-pop writes a slot that is immediately released.
  always_ff @(posedge clk) begin
    if (!rstn && inflight_q) begin
      mem_q[wr_ptr_q] <= i_rddata;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= IDLE;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
`ifdef FIFO_RD_STREAM_PKTCNT_EN
      pkt_q      <= '0;
      und_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_en) state_q <= RUN;
        end
        RUN: begin
          if (!i_en) state_q <= DRAIN;
        end
        DRAIN: begin
          if (i_en) begin
            state_q <= RUN;
          end else if (occ_d == 2'd0 && !o_rden) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      occ_q      <= occ_d;
      inflight_q <= o_rden;
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)        rd_ptr_q <= ~rd_ptr_q;

      if (pop) begin
        beat_q <= is_last ? '0 : beat_q + 1'b1;
      end

`ifdef FIFO_RD_STREAM_PKTCNT_EN
      if (pop && is_last) pkt_q <= pkt_q + 1'b1;
      if (state_q == RUN && !o_valid && i_ready && i_empty) begin
        und_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed table plus randomized traffic for
// fifo_rd_stream, checked against a word-count reference model.
module tb_fifo_rd_stream;

  localparam int W   = 128;
  localparam int PKT = 4;
  localparam int CW  = 16;
  localparam int FD  = 4096;

  logic         clk = 1'b0;
  logic         rstn;
  logic         i_en;
  logic         i_empty;
  logic         o_rden;
  logic [W-1:0] i_rddata;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_last;
  logic         o_busy;
`ifdef FIFO_RD_STREAM_PKTCNT_EN
  logic [CW-1:0] o_pkt_cnt;
  logic          o_underrun;
`endif

  fifo_rd_stream #(
    .WIDTH  (W),
    .PKT_LEN(PKT),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (i_en),
    .i_empty   (i_empty),
    .o_rden    (o_rden),
    .i_rddata  (i_rddata),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_last    (o_last),
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    .o_pkt_cnt (o_pkt_cnt),
    .o_underrun(o_underrun),
`endif
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  // Source FIFO: flat word array, registered read.
  logic [W-1:0] fmem [FD];
  int wr_idx = 0;
  int rd_idx = 0;

  assign i_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (o_rden) begin
      i_rddata <= fmem[rd_idx];
      rd_idx   <= rd_idx + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           deliv_idx = 0;
  int           mstate    = 0;
  int           beats     = 0;
  int           n_rden    = 0;
  int           n_lasts   = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic [CW-1:0] pkt_m = '0;
  bit           und_m = 0;

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h",
               name, $time, act, exp);
    end
  endtask

  task automatic push(logic [W-1:0] w);
    fmem[wr_idx] = w;
    wr_idx++;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mstate     = 0;
    beats      = 0;
    prev_stall = 0;
    pkt_m      = '0;
    und_m      = 0;
    deliv_idx  = rd_idx;
  endtask

  task automatic do_reset(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rstn    = 1'b1;
      i_en    = 1'b0;
      i_ready = 1'b0;
      #1;
      chk("rst_rden", o_rden, 0);
    end
    model_reset();
  endtask

  task automatic drive(bit en, bit rdy);
    @(negedge clk);
    rstn    = 1'b0;
    i_en    = en;
    i_ready = rdy;
    #1;
  endtask

  // One cycle of the model: words in flight = read from the FIFO but
  // not yet delivered; every check is phrased in those counts.
  task automatic model_step();
    int  words;
    int  words_nx;
    bit  pop_m;
    bit  last_m;
    bit  rden_m;
    words  = rd_idx - deliv_idx;
    pop_m  = (words > 0) && i_ready;
    last_m = (words > 0) && ((beats % PKT) == PKT - 1);
    rden_m = (mstate == 1) && i_en && (rd_idx != wr_idx)
             && (words - int'(pop_m) < 2);

    chk("occupancy_le2", (words <= 2), 1);
    chk("valid", o_valid, (words > 0));
    chk("busy", o_busy, (mstate != 0));
    chk("rden", o_rden, rden_m);
    chk("last", o_last, last_m);
    if (words > 0) chk("data", o_data, fmem[deliv_idx]);
    if (prev_stall) chk("stall_hold", o_data, prev_data);
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    chk("pkt_cnt", o_pkt_cnt, pkt_m);
    chk("underrun", o_underrun, und_m);
    if (mstate == 1 && words == 0 && i_ready
        && rd_idx == wr_idx) und_m = 1;
    if (pop_m && last_m) pkt_m = pkt_m + 1'b1;
`endif

    if (rden_m) n_rden++;
    if (pop_m && last_m) n_lasts++;
    prev_stall = (words > 0) && !i_ready;
    prev_data  = o_data;
    if (pop_m) begin
      deliv_idx++;
      beats++;
    end

    words_nx = words - int'(pop_m) + int'(rden_m);
    case (mstate)
      0: if (i_en) mstate = 1;
      1: if (!i_en) mstate = 2;
      default: begin
        if (i_en) mstate = 1;
        else if (words_nx == 0) mstate = 0;
      end
    endcase
  endtask

  task automatic cyc(bit en, bit rdy);
    drive(en, rdy);
    model_step();
  endtask

  task automatic settle();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b1);
      if (!o_busy) break;
    end
    chk("settle_idle", o_busy, 0);
  endtask

  typedef struct {
    bit           en;
    bit           rdy;
    bit           rden;
    bit           valid;
    logic [W-1:0] data;
    bit           last;
    bit           busy;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int s_rd;
    int s_dv;
    int s_la;
    int k;
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    logic [CW-1:0] s_pk;
`endif
    rstn     = 1'b1;
    i_en     = 1'b0;
    i_ready  = 1'b0;
    i_rddata = '0;

    tbl[0] = '{1, 1, 0, 0, 128'h0, 0, 0};
    tbl[1] = '{1, 1, 1, 0, 128'h0, 0, 1};
    tbl[2] = '{1, 1, 1, 1, 128'h1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 128'h2, 0, 1};
    tbl[4] = '{1, 1, 1, 1, 128'h3, 0, 1};
    tbl[5] = '{1, 1, 0, 1, 128'h4, 1, 1};
    tbl[6] = '{1, 1, 0, 0, 128'h0, 0, 1};
    tbl[7] = '{0, 1, 0, 0, 128'h0, 0, 1};
    tbl[8] = '{0, 1, 0, 0, 128'h0, 0, 1};
    tbl[9] = '{0, 1, 0, 0, 128'h0, 0, 0};

    // Directed: preload 1..4, full-rate drain, stop.
    do_reset(2);
    chk("reset_valid", o_valid, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_last", o_last, 0);
    chk("reset_data", o_data, 0);
    for (int i = 1; i <= 4; i++) push(W'(i));
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].en, tbl[i].rdy);
      chk($sformatf("tbl%0d_rden", i), o_rden, tbl[i].rden);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].data);
      chk($sformatf("tbl%0d_last", i), o_last, tbl[i].last);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
      model_step();
    end

    // Framing: 8 words, two packets of 4.
    do_reset(1);
    for (int i = 0; i < 8; i++) push(rnd_word());
    s_la = n_lasts;
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    s_pk = pkt_m;
`endif
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
    settle();
    chk("two_packets", n_lasts - s_la, 2);
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    chk("pkt_cnt_two", o_pkt_cnt - s_pk, 2);
`endif

    // Backpressure pattern 1,0,0,1 over 10 words.
    for (int i = 0; i < 10; i++) push(rnd_word());
    s_dv = deliv_idx;
    k = 0;
    while ((deliv_idx - s_dv) < 10 && k < 80) begin
      cyc(1'b1, (k % 4 == 0) || (k % 4 == 3));
      k++;
    end
    chk("bp_delivered", deliv_idx - s_dv, 10);
    settle();

    // Graceful stop after three reads with a long stall.
    for (int i = 0; i < 6; i++) push(rnd_word());
    s_rd = n_rden;
    s_dv = deliv_idx;
    k = 0;
    while ((n_rden - s_rd) < 3 && k < 20) begin
      cyc(1'b1, 1'b1);
      k++;
    end
    chk("stop_three_reads", n_rden - s_rd, 3);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    settle();
    chk("stop_no_more_rden", n_rden - s_rd, 3);
    chk("stop_delivered", deliv_idx - s_dv, 3);

    // Reset while the skid path is full.
    do_reset(1);
    for (int i = 0; i < 6; i++) push(rnd_word());
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("full_before_rst", rd_idx - deliv_idx, 2);
    do_reset(1);
    drive(1'b1, 1'b1);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_busy", o_busy, 0);
    model_step();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
    settle();

    // Empty FIFO while running.
    do_reset(1);
    while (rd_idx != wr_idx) begin
      rd_idx = wr_idx;
      deliv_idx = wr_idx;
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1);
      chk("empty_rden", o_rden, 0);
      chk("empty_valid", o_valid, 0);
    end
`ifdef FIFO_RD_STREAM_PKTCNT_EN
    chk("underrun_set", o_underrun, 1);
    cyc(1'b1, 1'b0);
    chk("underrun_sticky", o_underrun, 1);
`endif
    settle();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      @(negedge clk);
      rstn    = 1'b0;
      i_en    = ($urandom_range(0, 7) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      if (wr_idx < FD - 8 && $urandom_range(0, 2) == 0) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) begin
          push(rnd_word());
        end
      end
      #1;
      model_step();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
